// File: rtl/trace_pkg.sv
// Shared definitions for the trace-command path: opcodes, default address
// geometry and the request layout handed to the L1 cache controller.
package trace_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int OFFSET_W_DEF = 6;
  localparam int INDEX_W_DEF  = 14;
  localparam int TAG_W_DEF    = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF;

  typedef enum logic [3:0] {
    OP_READ   = 4'd0,
    OP_WRITE  = 4'd1,
    OP_IFETCH = 4'd2,
    OP_INVAL  = 4'd3,
    OP_SNOOP  = 4'd4,
    OP_CLEAR  = 4'd8,
    OP_PRINT  = 4'd9
  } opcode_e;

  typedef struct packed {
    logic [3:0]              op;
    logic [TAG_W_DEF-1:0]    tag;
    logic [INDEX_W_DEF-1:0]  index;
    logic [OFFSET_W_DEF-1:0] offset;
  } cache_req_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    case (op)
      OP_READ, OP_WRITE, OP_IFETCH, OP_INVAL, OP_SNOOP, OP_CLEAR, OP_PRINT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Clear and print act on the whole cache, so their address is meaningless.
  function automatic logic op_uses_addr(input logic [3:0] op);
    return !(op == OP_CLEAR || op == OP_PRINT);
  endfunction

endpackage

// File: rtl/trace_cmd_receiver_sync_fifo.sv
// Synchronous FIFO with extra-MSB read/write pointers; read data is the
// combinational head entry, valid whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_cmd_receiver.sv
// Receives {instruction, address} trace commands, rejects bad opcodes, splits
// the address into tag/index/offset and issues buffered requests to the cache.
module trace_cmd_receiver
  import trace_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter int  ADDR_W   = ADDR_W_DEF,
  parameter int  OFFSET_W = OFFSET_W_DEF,
  parameter int  INDEX_W  = INDEX_W_DEF,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_instruction,
  input  logic [ADDR_W-1:0]   cmd_address,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [3:0]          req_op,
  output logic [TAG_W-1:0]    req_tag,
  output logic [INDEX_W-1:0]  req_index,
  output logic [OFFSET_W-1:0] req_offset,
  output logic                bad_cmd,
  output logic [31:0]         accept_count,
  output logic [15:0]         bad_count,
  output logic                idle
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Same layout as cache_req_t, sized from this instance's parameters.
  typedef struct packed {
    logic [3:0]          op;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } req_t;

  req_t             cmd_entry, fifo_rdata, req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic             bad_q, bad_d;
  logic [31:0]      accept_q, accept_d;
  logic [15:0]      bad_cnt_q, bad_cnt_d;
  logic             fifo_full, fifo_empty, push, pop, cmd_fire, op_ok;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;

  // The output register counts toward capacity, so DEPTH commands in flight
  // close the input; the test depends only on registered state.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, req_valid_q};
  assign cmd_ready = !fifo_full && (occupancy < (CNT_W+1)'(DEPTH));

  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_ok    = is_valid_op(cmd_instruction);
  assign push     = cmd_fire && op_ok;
  assign pop      = !fifo_empty && (!req_valid_q || req_ready);

  always_comb begin
    cmd_entry.op     = cmd_instruction;
    cmd_entry.tag    = '0;
    cmd_entry.index  = '0;
    cmd_entry.offset = '0;
    if (op_uses_addr(cmd_instruction)) begin
      cmd_entry.tag    = cmd_address[ADDR_W-1:INDEX_W+OFFSET_W];
      cmd_entry.index  = cmd_address[INDEX_W+OFFSET_W-1:OFFSET_W];
      cmd_entry.offset = cmd_address[OFFSET_W-1:0];
    end
  end

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (cmd_entry),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    req_d       = req_q;
    req_valid_d = req_valid_q;
    if (pop) begin
      req_d       = fifo_rdata;
      req_valid_d = 1'b1;
    end else if (req_ready) begin
      req_valid_d = 1'b0;
    end
    bad_d     = cmd_fire && !op_ok;
    accept_d  = accept_q + 32'(push);
    bad_cnt_d = (bad_d && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      req_valid_q <= 1'b0;
      bad_q       <= 1'b0;
      accept_q    <= '0;
      bad_cnt_q   <= '0;
    end else begin
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      bad_q       <= bad_d;
      accept_q    <= accept_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_op       = req_q.op;
  assign req_tag      = req_q.tag;
  assign req_index    = req_q.index;
  assign req_offset   = req_q.offset;
  assign bad_cmd      = bad_q;
  assign accept_count = accept_q;
  assign bad_count    = bad_cnt_q;
  assign idle         = fifo_empty && !req_valid_q;

endmodule

// File: tb/tb_trace_cmd_receiver.sv
// Scenario bench for trace_cmd_receiver: expected requests are queued on
// command acceptance and compared in order as the receiver issues them.
module tb_trace_cmd_receiver;

  localparam int REQ_W = 36;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_instruction = '0;
  logic [31:0] cmd_address = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [3:0]  req_op;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        bad_cmd;
  logic [31:0] accept_count;
  logic [15:0] bad_count;
  logic        idle;

  always #5 clock = ~clock;

  trace_cmd_receiver dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_instruction (cmd_instruction),
    .cmd_address     (cmd_address),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_tag         (req_tag),
    .req_index       (req_index),
    .req_offset      (req_offset),
    .bad_cmd         (bad_cmd),
    .accept_count    (accept_count),
    .bad_count       (bad_count),
    .idle            (idle)
  );

  // ---------------- scoreboard ----------------
  logic [REQ_W-1:0] exp_q[$];
  logic [REQ_W-1:0] mon_got, mon_exp;
  int n_checks = 0;
  int n_fail = 0;
  int retired = 0;
  int bad_pulses = 0;
  int exp_accept = 0;
  int exp_bad = 0;
  logic [3:0] valid_ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

  function automatic logic model_valid(input logic [3:0] op);
    return (op <= 4'd4) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // tag|index|offset concatenated is the address itself.
  function automatic logic [REQ_W-1:0] model_req(input logic [3:0] op, input logic [31:0] addr);
    if (op == 4'd8 || op == 4'd9) return {op, 32'h0};
    return {op, addr};
  endfunction

  always @(negedge clock) begin
    if (bad_cmd) bad_pulses++;
    if (!reset && req_valid && req_ready) begin
      mon_got = {req_op, req_tag, req_index, req_offset};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: got %h, expected no request", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL req_order: got %h, expected %h", mon_got, mon_exp);
        end
      end
      retired++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [31:0] addr);
    bit ok = 0;
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_instruction = op;
    cmd_address = addr;
    while (!ok && waited < 200) begin
      ok = cmd_ready;
      @(posedge clock); #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout: op %0d not accepted in 200 cycles", op);
    end else if (model_valid(op)) begin
      exp_q.push_back(model_req(op, addr));
      exp_accept++;
    end else begin
      exp_bad++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain: %0d pending, idle %b, expected 0 pending and idle 1", tag, exp_q.size(), idle);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    n_checks++; if ({req_op, req_tag, req_index, req_offset} !== 36'h0) begin
      n_fail++; $display("FAIL reset_req_fields: got %h expected 0", {req_op, req_tag, req_index, req_offset}); end
    n_checks++; if (bad_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_bad_cmd: got %b expected 0", bad_cmd); end
    n_checks++; if (accept_count !== 32'd0) begin n_fail++; $display("FAIL reset_accept_count: got %0d expected 0", accept_count); end
    n_checks++; if (bad_count !== 16'd0) begin n_fail++; $display("FAIL reset_bad_count: got %0d expected 0", bad_count); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_single_read();
    req_ready = 1'b1;
    send_cmd(4'd0, 32'h1234_5678);
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL read_no_bypass: req_valid %b expected 0", req_valid); end
    @(posedge clock); #1;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL read_latency: req_valid %b expected 1", req_valid); end
    n_checks++; if (req_op !== 4'd0) begin n_fail++; $display("FAIL read_op: got %0d expected 0", req_op); end
    n_checks++; if (req_tag !== 12'h123) begin n_fail++; $display("FAIL read_tag: got %h expected 123", req_tag); end
    n_checks++; if (req_index !== 14'h1159) begin n_fail++; $display("FAIL read_index: got %h expected 1159", req_index); end
    n_checks++; if (req_offset !== 6'h38) begin n_fail++; $display("FAIL read_offset: got %h expected 38", req_offset); end
    n_checks++; if (accept_count !== 32'd1) begin n_fail++; $display("FAIL read_accept_count: got %0d expected 1", accept_count); end
    wait_drain("read");
  endtask

  task automatic test_backpressure();
    int base = retired;
    logic [REQ_W-1:0] held;
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(4'd1, $urandom);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: cmd_ready %b expected 0", cmd_ready); end
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_req_valid: got %b expected 1", req_valid); end
    held = {req_op, req_tag, req_index, req_offset};
    fork
      send_cmd(4'd1, $urandom);
      begin
        repeat (3) begin
          @(posedge clock); #1;
          n_checks++;
          if ({req_op, req_tag, req_index, req_offset} !== held || req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got %h valid %b, expected %h valid 1",
                     {req_op, req_tag, req_index, req_offset}, req_valid, held);
          end
        end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: cmd_ready %b expected 0", cmd_ready); end
        req_ready = 1'b1;
      end
    join
    wait_drain("bp");
    n_checks++; if (retired - base != 5) begin n_fail++; $display("FAIL bp_retired: got %0d expected 5", retired - base); end
    n_checks++; if (accept_count !== 32'(exp_accept)) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected %0d", accept_count, exp_accept); end
  endtask

  task automatic test_bad_opcode();
    int bp = bad_pulses;
    int base = retired;
    logic [3:0] bad_ops [8] = '{4'd5, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    req_ready = 1'b1;
    send_cmd(4'd6, $urandom);
    n_checks++; if (bad_cmd !== 1'b1) begin n_fail++; $display("FAIL bad_pulse: bad_cmd %b expected 1", bad_cmd); end
    send_cmd(4'd1, $urandom);
    wait_drain("bad");
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (bad_pulses - bp != 1) begin n_fail++; $display("FAIL bad_pulse_count: got %0d expected 1", bad_pulses - bp); end
    n_checks++; if (bad_count !== 16'd1) begin n_fail++; $display("FAIL bad_count: got %0d expected 1", bad_count); end
    n_checks++; if (retired - base != 1) begin n_fail++; $display("FAIL bad_only_write: retired %0d expected 1", retired - base); end
    n_checks++; if (accept_count !== 32'(exp_accept)) begin n_fail++; $display("FAIL bad_accept_count: got %0d expected %0d", accept_count, exp_accept); end
    bp = bad_pulses;
    for (int i = 0; i < 8; i++) send_cmd(bad_ops[i], $urandom);
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (bad_count !== 16'(exp_bad)) begin n_fail++; $display("FAIL bad_count_all: got %0d expected %0d", bad_count, exp_bad); end
    n_checks++; if (bad_pulses - bp != 8) begin n_fail++; $display("FAIL bad_cycles_all: got %0d expected 8", bad_pulses - bp); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bad_idle: got %b expected 1", idle); end
  endtask

  task automatic test_clear_print();
    req_ready = 1'b1;
    send_cmd(4'd8, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    n_checks++; if (req_valid !== 1'b1 || req_op !== 4'd8) begin
      n_fail++; $display("FAIL clear_op: valid %b op %0d expected valid 1 op 8", req_valid, req_op); end
    n_checks++; if ({req_tag, req_index, req_offset} !== 32'h0) begin
      n_fail++; $display("FAIL clear_addr: got %h expected 0", {req_tag, req_index, req_offset}); end
    send_cmd(4'd9, $urandom);
    wait_drain("print");
  endtask

  task automatic test_back_to_back();
    int base = retired;
    int bubbles = 0;
    int cyc = 0;
    bit seen = 0;
    req_ready = 1'b1;
    fork
      for (int i = 0; i < 64; i++) send_cmd(valid_ops[$urandom_range(0, 6)], $urandom);
      while (retired - base < 64 && cyc < 400) begin
        @(posedge clock); #1;
        cyc++;
        if (req_valid) seen = 1;
        else if (seen && retired - base < 64) bubbles++;
      end
    join
    wait_drain("stream");
    n_checks++; if (retired - base != 64) begin n_fail++; $display("FAIL stream_count: got %0d expected 64", retired - base); end
    n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL stream_bubbles: got %0d expected 0", bubbles); end
    n_checks++; if (accept_count !== 32'(exp_accept)) begin n_fail++; $display("FAIL stream_accept_count: got %0d expected %0d", accept_count, exp_accept); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(4'd2, $urandom);
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", req_valid); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b expected 0", req_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (accept_count !== 32'd0 || bad_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_counters: accept %0d bad %0d expected 0 0", accept_count, bad_count); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b expected 1", idle); end
    exp_q.delete();
    exp_accept = 0;
    exp_bad = 0;
    @(negedge clock) reset = 1'b0;
    req_ready = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_req: req_valid %b expected 0", req_valid); end
    end
    send_cmd(4'd0, 32'hCAFE_0040);
    wait_drain("mid");
    n_checks++; if (accept_count !== 32'd1) begin n_fail++; $display("FAIL mid_recover_count: got %0d expected 1", accept_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_bad_opcode();
    test_clear_print();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
